// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU slice: the program loader FSM state
// encoding, the nibble width, and the default address and instruction widths
// that the CPU, the program memory and the loader all agree on.
package cpu4_pkg;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned INSTR_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles MSB-first into INSTR_W-bit words.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   clear          : synchronous clear of the partial word and nibble count
//   shift          : a nibble is accepted this cycle
//   nibble         : the accepted nibble
//   word_next      : the packing register with nibble shifted in (valid when shift)
//   complete       : this shift fills the final nibble slot of the word
module nibble_packer
  import cpu4_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                shift,
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [INSTR_W-1:0]  word_next,
  output logic                complete
);

  localparam int unsigned NPW   = INSTR_W / NIBBLE_W;
  localparam int unsigned CNT_W = (NPW > 1) ? $clog2(NPW) : 1;

  logic [INSTR_W-1:0] shreg;
  logic [CNT_W-1:0]   count;

  // After NPW shifts, the first nibble has reached the top slot.
  always_comb begin
    word_next = {shreg[INSTR_W-NIBBLE_W-1:0], nibble};
    complete  = shift && (count == CNT_W'(NPW - 1));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      count <= '0;
    end else if (shift) begin
      shreg <= word_next;
      count <= complete ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Writer side of the 4-bit CPU's program memory. Accepts a nibble stream over
// valid/ready, packs nibbles into instruction words, writes them sequentially
// from address 0, verifies a trailing XOR checksum nibble and then releases
// the CPU from reset.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   start                : one-cycle pulse beginning a load (IDLE/DONE/ERR only)
//   in_data/in_valid/in_ready/in_last : nibble stream handshake
//   mem_we/mem_addr/mem_wdata         : program memory write port
//   cpu_reset            : high holds the CPU in reset
//   busy/done/error      : load status; done and error are sticky
module prog_loader
  import cpu4_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INSTR_W-1:0]  mem_wdata,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);

  loader_state_t       state;
  logic [ADDR_W-1:0]   wr_addr;
  logic [NIBBLE_W-1:0] csum;
  logic                xfer;
  logic                load_xfer;
  logic                restart;
  logic                last_word;
  logic [INSTR_W-1:0]  word_next;
  logic                complete;

  always_comb begin
    xfer      = in_valid && in_ready;
    load_xfer = xfer && (state == LOAD);
    restart   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    last_word = (wr_addr == ADDR_W'(DEPTH - 1));
  end

  nibble_packer #(
    .INSTR_W (INSTR_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart),
    .shift     (load_xfer),
    .nibble    (in_data),
    .word_next (word_next),
    .complete  (complete)
  );

  // Outputs are registered alongside the state; each transition sets the
  // output values belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
      wr_addr   <= '0;
      csum      <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            wr_addr   <= '0;
            csum      <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            csum <= csum ^ in_data;
            if (complete) begin
              mem_we    <= 1'b1;
              mem_addr  <= wr_addr;
              mem_wdata <= word_next;
              wr_addr   <= wr_addr + 1'b1;
              // Leaving for CHK on the final word keeps wr_addr from wrapping.
              if (in_last || last_word) begin
                state <= CHK;
              end
            end else if (in_last) begin
              state    <= ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end
          end
        end
        CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;

  int total = 0;
  int bad   = 0;

  // write log and memory image observed on the write port
  logic [7:0] wdata_log [0:31];
  logic [3:0] waddr_log [0:31];
  logic [7:0] mem_img   [0:15];
  int n_wr  = 0;
  int n_xfr = 0;
  int dbl   = 0;
  logic prev_we = 1'b0;

  logic [3:0] bs [0:5];

  prog_loader #(
    .INSTR_W (8),
    .ADDR_W  (4),
    .DEPTH   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      if (n_wr < 32) begin
        wdata_log[n_wr] = mem_wdata;
        waddr_log[n_wr] = mem_addr;
      end
      mem_img[mem_addr] = mem_wdata;
      n_wr = n_wr + 1;
    end
    if (mem_we && prev_we) dbl = dbl + 1;
    prev_we = mem_we;
    if (in_valid && in_ready) n_xfr = n_xfr + 1;
  end

  // All tasks start and end just after a falling edge.
  task automatic send_nib(input logic [3:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      ok = in_ready;
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: in_ready never seen for nibble %0h", d);
    end
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    n_wr  = 0;
    n_xfr = 0;
    dbl   = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    total++; if (mem_we !== 1'b0)    begin bad++; $display("FAIL rst_mem_we: got %b exp 0", mem_we); end
    total++; if (mem_addr !== 4'h0)  begin bad++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
    total++; if (mem_wdata !== 8'h0) begin bad++; $display("FAIL rst_mem_wdata: got %h exp 00", mem_wdata); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b exp 0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done: got %b exp 0", done); end
    total++; if (error !== 1'b0)     begin bad++; $display("FAIL rst_error: got %b exp 0", error); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset: got %b exp 1", cpu_reset); end
  endtask

  // 1,A,2,B,3,C -> XOR = D
  task automatic test_basic();
    clear_log();
    pulse_start();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b exp 1", in_ready); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL basic_busy: got %b exp 1", busy); end
    send_nib(bs[0], 1'b0);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL basic_no_early_we: got %b exp 0", mem_we); end
    send_nib(bs[1], 1'b0);
    total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'h0, 8'h1A})
      begin bad++; $display("FAIL basic_wr_latency: got we=%b a=%h d=%h exp we=1 a=0 d=1a", mem_we, mem_addr, mem_wdata); end
    send_nib(bs[2], 1'b0);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL basic_we_pulse: got %b exp 0", mem_we); end
    send_nib(bs[3], 1'b0);
    send_nib(bs[4], 1'b0);
    send_nib(bs[5], 1'b1);
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL basic_cpu_held: got %b exp 1", cpu_reset); end
    send_nib(4'hD, 1'b0);
    gap(1);
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL basic_cpu_release: got %b exp 0", cpu_reset); end
    total++; if ({done, error, busy, in_ready} !== 4'b1000)
      begin bad++; $display("FAIL basic_status: got d/e/b/r=%b exp 1000", {done, error, busy, in_ready}); end
    total++; if (n_wr !== 3) begin bad++; $display("FAIL basic_nwr: got %0d exp 3", n_wr); end
    total++; if ({waddr_log[0], wdata_log[0], waddr_log[1], wdata_log[1], waddr_log[2], wdata_log[2]} !==
                 {4'h0, 8'h1A, 4'h1, 8'h2B, 4'h2, 8'h3C})
      begin bad++; $display("FAIL basic_writes: got %h:%h %h:%h %h:%h exp 0:1a 1:2b 2:3c",
        waddr_log[0], wdata_log[0], waddr_log[1], wdata_log[1], waddr_log[2], wdata_log[2]); end
    total++; if (dbl !== 0) begin bad++; $display("FAIL basic_we_double: got %0d exp 0", dbl); end
  endtask

  task automatic test_bad_csum();
    clear_log();
    pulse_start();
    total++; if ({done, cpu_reset, busy} !== 3'b011)
      begin bad++; $display("FAIL badck_restart: got done/cpu_reset/busy=%b exp 011", {done, cpu_reset, busy}); end
    for (int i = 0; i < 6; i++) send_nib(bs[i], i == 5);
    send_nib(4'h0, 1'b0);
    gap(1);
    total++; if ({error, done, cpu_reset, in_ready, busy} !== 5'b10100)
      begin bad++; $display("FAIL badck_status: got e/d/c/r/b=%b exp 10100", {error, done, cpu_reset, in_ready, busy}); end
    total++; if (n_wr !== 3) begin bad++; $display("FAIL badck_nwr: got %0d exp 3", n_wr); end
  endtask

  task automatic test_gaps();
    clear_log();
    pulse_start();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL gaps_err_clear: got %b exp 0", error); end
    for (int i = 0; i < 6; i++) begin
      send_nib(bs[i], i == 5);
      gap($urandom_range(0, 3));
      if (i == 2) pulse_start();   // ignored mid-load
    end
    send_nib(4'hD, 1'b1);
    gap(3);
    total++; if (n_xfr !== 7) begin bad++; $display("FAIL gaps_nxfer: got %0d exp 7", n_xfr); end
    total++; if ({wdata_log[0], wdata_log[1], wdata_log[2]} !== 24'h1A2B3C)
      begin bad++; $display("FAIL gaps_writes: got %h %h %h exp 1a 2b 3c", wdata_log[0], wdata_log[1], wdata_log[2]); end
    total++; if ({done, error, cpu_reset} !== 3'b100)
      begin bad++; $display("FAIL gaps_status: got d/e/c=%b exp 100", {done, error, cpu_reset}); end
  endtask

  // nibble i = i mod 16; XOR over two passes of 0..F is 0
  task automatic test_full();
    int nbad;
    logic [7:0] exp_w;
    clear_log();
    pulse_start();
    for (int i = 0; i < 32; i++) send_nib(4'(i), 1'b0);
    gap(2);
    total++; if ({busy, in_ready, done, error} !== 4'b1100)
      begin bad++; $display("FAIL full_in_chk: got b/r/d/e=%b exp 1100", {busy, in_ready, done, error}); end
    total++; if (n_wr !== 16) begin bad++; $display("FAIL full_nwr: got %0d exp 16", n_wr); end
    nbad = 0;
    for (int k = 0; k < 16; k++) begin
      exp_w = {4'(2 * k), 4'(2 * k + 1)};
      if (waddr_log[k] !== 4'(k) || wdata_log[k] !== exp_w) nbad++;
    end
    total++; if (nbad !== 0) begin bad++; $display("FAIL full_writes: got %0d wrong entries exp 0", nbad); end
    send_nib(4'h0, 1'b1);   // in_last on checksum is ignored
    gap(1);
    total++; if ({done, error, cpu_reset, n_wr} !== {3'b100, 32'd16})
      begin bad++; $display("FAIL full_done: got d/e/c=%b nwr=%0d exp 100 nwr=16", {done, error, cpu_reset}, n_wr); end
  endtask

  task automatic test_framing();
    clear_log();
    pulse_start();
    send_nib(4'h1, 1'b0);
    send_nib(4'hA, 1'b0);
    send_nib(4'h2, 1'b1);   // in_last on first nibble of a word
    gap(3);
    total++; if ({error, done, busy, in_ready, cpu_reset} !== 5'b10001)
      begin bad++; $display("FAIL frame_status: got e/d/b/r/c=%b exp 10001", {error, done, busy, in_ready, cpu_reset}); end
    total++; if (n_wr !== 1) begin bad++; $display("FAIL frame_nwr: got %0d exp 1", n_wr); end
  endtask

  task automatic test_reset_mid();
    mem_img[0] = 8'h00;
    clear_log();
    pulse_start();
    send_nib(4'h5, 1'b0);
    send_nib(4'h6, 1'b0);
    send_nib(4'h7, 1'b0);
    gap(0);
    test_reset();
    total++; if (mem_img[0] !== 8'h56) begin bad++; $display("FAIL rstmid_partial: got %h exp 56", mem_img[0]); end
    test_basic();
    total++; if (mem_img[0] !== 8'h1A) begin bad++; $display("FAIL rstmid_rewrite: got %h exp 1a", mem_img[0]); end
  endtask

  initial begin
    bs[0] = 4'h1; bs[1] = 4'hA; bs[2] = 4'h2;
    bs[3] = 4'hB; bs[4] = 4'h3; bs[5] = 4'hC;
    reset    = 1'b1;
    start    = 1'b0;
    in_data  = 4'h0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_csum();
    test_gaps();
    test_full();
    test_framing();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the 4-bit CPU's program memory.
- Accepts a nibble stream from a host over a valid/ready handshake, packs nibbles into instruction words, and writes them sequentially into program memory starting at address 0.
- Verifies a trailing XOR checksum nibble, then releases the CPU from reset so its pc starts fetching at 0.
- Sits between the host or bench and the CPU/program memory pair.

Parameters:
- INSTR_W, 8, instruction width in bits; must be a multiple of 4.
- ADDR_W, 4, program memory address width, matching the pc width.
- DEPTH, 16, number of program words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- in_data  input  4  stream nibble.
- in_valid  input  1  in_data is valid.
- in_last  input  1  marks the final data nibble of the program.
- in_ready  output  1  loader accepts a nibble this cycle.
- mem_we  output  1  program memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  INSTR_W  write data.
- cpu_reset  output  1  held-reset for the CPU; high means the CPU is held.
- busy  output  1  load in progress.
- done  output  1  load succeeded; sticky until the next start or reset.
- error  output  1  load failed; sticky until the next start or reset.

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, error=0.
  - cpu_reset=1.
  - Internal counters and checksum are cleared.
- Handshake: a nibble transfers on any rising edge where in_valid && in_ready. in_ready is a registered-state decode: 1 in LOAD and CHK, 0 otherwise. in_data and in_last are ignored when no transfer occurs.
- States:
  - IDLE: cpu_reset=1. start moves to LOAD and clears wr_addr, the nibble count, the checksum, done and error.
  - LOAD: busy=1, cpu_reset=1.
    - Each transfer shifts the nibble into the packing register MSB-first: the first nibble of a word becomes bits [INSTR_W-1:INSTR_W-4]. It also XORs the nibble into the checksum.
    - The nibble counter counts 0..INSTR_W/4-1 and wraps.
    - On the transfer that completes a word: on the next cycle mem_we=1 for exactly one cycle, with mem_addr=wr_addr and mem_wdata=the packed word; wr_addr then increments.
    - A completing transfer with in_last=1, or the completion of word DEPTH-1, goes to CHK. wr_addr does not wrap into a second pass.
    - in_last=1 on a non-completing nibble is a framing error: go to ERR with no write.
  - CHK: busy=1, cpu_reset=1. Accepts exactly one nibble, the checksum; in_last on it is ignored. If it equals the running XOR, go to DONE, otherwise go to ERR.
  - DONE: done=1, busy=0, in_ready=0. cpu_reset goes 0 on the cycle DONE is entered.
  - ERR: error=1, busy=0, cpu_reset=1.
- start handling:
  - In DONE or ERR, start re-enters LOAD: cpu_reset goes back to 1 the next cycle and done/error clear.
  - start in LOAD or CHK is ignored.
- Latency: the write strobe trails the completing transfer by 1 cycle. cpu_reset deasserts 1 cycle after a matching checksum transfer.
- Simultaneous events: reset has priority over everything. A transfer that coincides with a pending mem_we is legal; at most one write occurs per cycle because a word takes at least 2 transfers when INSTR_W>=8.
- Reset during LOAD or CHK: return to IDLE and abandon the partial word. Memory contents already written are left as-is, and cpu_reset stays 1.

Decomposition:
- Shared package cpu4_pkg:
  - loader state enum {IDLE, LOAD, CHK, DONE, ERR}.
  - NIBBLE_W=4.
  - Defaults for ADDR_W and INSTR_W, shared with the CPU and the program memory.
- One sub-module: nibble_packer, which holds the shift register, nibble counter and word-complete flag.
- The FSM, address counter and checksum stay in prog_loader.

Test Plan:
- Basic load: start; send nibbles 1,A,2,B,3,C with in_last on C; checksum D → writes 0:0x1A, 1:0x2B, 2:0x3C, each mem_we exactly 1 cycle; done=1; cpu_reset falls 1 cycle after the checksum transfer; CPU pc advances from 0.
- Bad checksum: same stream with checksum 0 → three writes, then error=1, cpu_reset stays 1, in_ready=0.
- Backpressure and gaps: same stream with in_valid low for 0–3 random cycles between nibbles → identical writes and done. No transfer occurs while in_valid=0.
- Full memory: 32 nibbles with no in_last → 16 writes at addr 0..15, no wrap; the 33rd nibble is taken as the checksum.
- Framing: in_last on the first nibble of a word → error=1, no write for that word.
- Reset mid-load: reset after 3 nibbles → all outputs at reset values, IDLE. A following start plus the basic stream → done, with addr 0 rewritten to 0x1A.
